vehicle_detector: RTL and testbench
===================================

# vehicle_detector

Vehicle detection front end for the four-approach signalised junction. Samples raw inductive-loop inputs, debounces them, and keeps a saturating per-approach queue count. Arrivals are counted when a debounced vehicle is first present; departures are modelled from the controller's green phase for that approach. Drives the `sensor_north/east/south/west` request lines consumed by the junction signal controller, and takes that controller's lamp outputs back as inputs.

## Interface
- `DEBOUNCE`, 4: consecutive synchronised samples required to accept a loop level change; must be ≥ 2.
- `DEPART`, 8: green cycles per modelled vehicle departure; must be ≥ 1.
- `QW`, 5: queue counter width; saturates at 2^QW−1.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `loop_n, loop_e, loop_s, loop_w`  in  1 each  raw loop detectors, asynchronous to `clk`.
- `ns_light, ew_light, sn_light, we_light`  in  3 each  controller lamps for the north, east, south and west approaches; red=001, yellow=010, green=100.
- `sensor_north, sensor_east, sensor_south, sensor_west`  out  1 each  approach has at least one queued vehicle.
- `queue_n, queue_e, queue_s, queue_w`  out  QW each  current queue count.
- `ovf`  out  4  sticky saturation flags, bit order {w,s,e,n}.

## Operation
- Four identical approach channels. Each has:
  - a 2-flop synchroniser on `loop_x`, giving output `s`;
  - a debounce FSM with counter `cnt`;
  - a departure timer `dt`;
  - the queue counter `q`.
- Debounce FSM states:
  - IDLE: if `s`=1, go to RISE with `cnt`=1.
  - RISE: if `s`=0, go to IDLE. Else if `cnt`==DEBOUNCE−1, go to PRESENT and raise an arrival pulse. Else increment `cnt`.
  - PRESENT: if `s`=0, go to FALL with `cnt`=1.
  - FALL: if `s`=1, go to PRESENT (no new arrival). Else if `cnt`==DEBOUNCE−1, go to IDLE. Else increment `cnt`.
- The arrival pulse lasts one cycle, and fires only on the RISE→PRESENT transition.
- Green test: approach is green iff its light input == 3'b100 exactly. Yellow, red and illegal codes all count as not green.
- Departure timer `dt`:
  - While not green, `dt` is held at 0.
  - While green, `dt` increments each cycle.
  - When `dt`==DEPART−1, `dt` returns to 0 and a departure pulse is raised if `q`>0.
  - A departure with `q`==0 has no effect.
- Queue update, per cycle:
  - arrival only: `q`+1, saturating. If `q` was already at maximum, set that channel's `ovf` bit.
  - departure only: `q`−1.
  - arrival and departure together: `q` unchanged, `ovf` not set.
- `sensor_x` = (`q_x` != 0), decoded combinationally from the registered `q`.
- `queue_x` is the register `q` itself.
- `ovf` bits clear only on `rst`.
- Channels are fully independent. Simultaneous events on different approaches have no interaction.

## Timing
- Reset, on the first rising `clk` edge with `rst`=1:
  - synchronisers, `cnt`, `dt`, `q` and `ovf` all 0;
  - FSMs in IDLE;
  - all `sensor_*` low, all `queue_*` 0.
- `rst` asserted mid-operation discards pending debounce progress and the queue contents on that edge.
- Arrival latency: with `loop_x` first sampled high at edge 0 and held high, `q` increments at edge DEBOUNCE+1 (edge 5 by default). `sensor_x` rises in the same cycle.
- Glitch rejection: a loop pulse that yields fewer than DEBOUNCE consecutive high values of `s` produces no arrival.
- Release: a vehicle is considered gone DEBOUNCE+1 edges after `loop_x` is first sampled low. A second arrival is possible only after that.
- Departure: with green first seen at edge g and `q`>0, the first decrement happens at edge g+DEPART−1. Subsequent decrements follow every DEPART edges while green holds.
- Green dropping before `dt` reaches DEPART−1 forfeits the partial interval. `dt` restarts from 0 at the next green.

## Test plan
- Reset, then `loop_n` high at edge 0 held 10 cycles, all lights red: `queue_n`=1 and `sensor_north`=1 from edge 5; no other channel changes.
- `loop_e` high for 2 cycles only: `queue_e` stays 0 and `sensor_east` stays 0.
- `queue_s`=3, then `sn_light`=100 for 24 cycles: `queue_s` reads 2, 1, 0 at green edges 7, 15, 23; `sensor_south` falls at edge 23.
- 33 debounced arrivals on west, light red: `queue_w` saturates at 31 and `ovf[3]`=1; a following `rst` clears both.
- `queue_n`=1 with `ns_light` green so that an arrival and a departure land on the same edge: `queue_n` stays 1 and `ovf` stays 0.
- `rst` pulsed while `loop_e` is mid-debounce in RISE: counting restarts from IDLE and the arrival edge is delayed accordingly.

Source files
------------

// File: rtl/vehicle_detector.sv
// vehicle_detector
//   Four-approach loop-detector front end for the junction signal controller.
//   Each approach synchronises its raw inductive loop, debounces it, counts
//   arrivals into a saturating queue and models departures from the green
//   phase of that approach. A non-empty queue raises the approach's request
//   line to the controller.
//
// Ports
//   clk                          system clock, rising edge
//   rst                          synchronous active-high reset
//   loop_n/e/s/w                 raw loop detectors (asynchronous to clk)
//   ns/ew/sn/we_light [2:0]      controller lamps for north/east/south/west
//                                (red=001, yellow=010, green=100)
//   sensor_north/east/south/west approach has at least one queued vehicle
//   queue_n/e/s/w [QW-1:0]       current queue counts
//   ovf [3:0]                    sticky saturation flags {w,s,e,n}
module vehicle_detector #(
  parameter int DEBOUNCE = 4,
  parameter int DEPART   = 8,
  parameter int QW       = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          loop_n,
  input  logic          loop_e,
  input  logic          loop_s,
  input  logic          loop_w,
  input  logic [2:0]    ns_light,
  input  logic [2:0]    ew_light,
  input  logic [2:0]    sn_light,
  input  logic [2:0]    we_light,
  output logic          sensor_north,
  output logic          sensor_east,
  output logic          sensor_south,
  output logic          sensor_west,
  output logic [QW-1:0] queue_n,
  output logic [QW-1:0] queue_e,
  output logic [QW-1:0] queue_s,
  output logic [QW-1:0] queue_w,
  output logic [3:0]    ovf
);

  localparam int CW = $clog2(DEBOUNCE);
  localparam int DW = (DEPART > 1) ? $clog2(DEPART) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
  localparam logic [DW-1:0] DT_LAST  = DW'(DEPART - 1);
  localparam logic [QW-1:0] Q_MAX    = {QW{1'b1}};

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RISE    = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;
  localparam logic [1:0] ST_FALL    = 2'd3;

  localparam logic [2:0] GREEN = 3'b100;

  // Channel index order: 0=north, 1=east, 2=south, 3=west.
  logic [3:0]    loops;
  logic [2:0]    light [4];
  logic [QW-1:0] q_all [4];
  logic [3:0]    ovf_all;

  assign loops    = {loop_w, loop_s, loop_e, loop_n};
  assign light[0] = ns_light;
  assign light[1] = ew_light;
  assign light[2] = sn_light;
  assign light[3] = we_light;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chan
      logic          sync1_reg;
      logic          s_reg;
      logic [1:0]    state_reg;
      logic [CW-1:0] cnt_reg;
      logic [DW-1:0] dt_reg;
      logic [QW-1:0] q_reg;
      logic          ovf_reg;
      logic          green;
      logic          arrival;
      logic          departure;

      // Only the exact green code counts; yellow, red and illegal codes do not.
      assign green = (light[gi] == GREEN);

      // Arrival and departure are decoded from current state so the queue
      // moves on the same edge the FSM/timer reaches its terminal condition.
      assign arrival   = (state_reg == ST_RISE) && s_reg && (cnt_reg == CNT_LAST);
      assign departure = green && (dt_reg == DT_LAST) && (q_reg != '0);

      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_reg <= 1'b0;
          s_reg     <= 1'b0;
        end else begin
          sync1_reg <= loops[gi];
          s_reg     <= sync1_reg;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
        end else begin
          case (state_reg)
            ST_IDLE: begin
              if (s_reg) begin
                state_reg <= ST_RISE;
                cnt_reg   <= CW'(1);
              end
            end
            ST_RISE: begin
              if (!s_reg) begin
                state_reg <= ST_IDLE;
              end else if (cnt_reg == CNT_LAST) begin
                state_reg <= ST_PRESENT;
              end else begin
                cnt_reg <= cnt_reg + CW'(1);
              end
            end
            ST_PRESENT: begin
              if (!s_reg) begin
                state_reg <= ST_FALL;
                cnt_reg   <= CW'(1);
              end
            end
            default: begin
              // Loop coming back during release is the same vehicle.
              if (s_reg) begin
                state_reg <= ST_PRESENT;
              end else if (cnt_reg == CNT_LAST) begin
                state_reg <= ST_IDLE;
              end else begin
                cnt_reg <= cnt_reg + CW'(1);
              end
            end
          endcase
        end
      end

      // A partial green interval is forfeited when green drops.
      always_ff @(posedge clk) begin
        if (rst || !green) begin
          dt_reg <= '0;
        end else if (dt_reg == DT_LAST) begin
          dt_reg <= '0;
        end else begin
          dt_reg <= dt_reg + DW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          q_reg   <= '0;
          ovf_reg <= 1'b0;
        end else if (arrival && !departure) begin
          if (q_reg == Q_MAX) begin
            ovf_reg <= 1'b1;
          end else begin
            q_reg <= q_reg + QW'(1);
          end
        end else if (departure && !arrival) begin
          q_reg <= q_reg - QW'(1);
        end
      end

      assign q_all[gi]   = q_reg;
      assign ovf_all[gi] = ovf_reg;
    end
  endgenerate

  assign queue_n      = q_all[0];
  assign queue_e      = q_all[1];
  assign queue_s      = q_all[2];
  assign queue_w      = q_all[3];
  assign sensor_north = (q_all[0] != '0);
  assign sensor_east  = (q_all[1] != '0);
  assign sensor_south = (q_all[2] != '0);
  assign sensor_west  = (q_all[3] != '0);
  assign ovf          = ovf_all;

endmodule

// File: tb/tb_vehicle_detector.sv
// Directed bench for vehicle_detector. Expected values are pushed to a
// scoreboard queue as stimulus is applied and popped/compared after the
// relevant clock edge.
module tb_vehicle_detector;

  localparam int QW = 5;
  localparam logic [2:0] RED   = 3'b001;
  localparam logic [2:0] GREEN = 3'b100;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          loop_n = 1'b0, loop_e = 1'b0, loop_s = 1'b0, loop_w = 1'b0;
  logic [2:0]    ns_light = RED, ew_light = RED, sn_light = RED, we_light = RED;
  logic          sensor_north, sensor_east, sensor_south, sensor_west;
  logic [QW-1:0] queue_n, queue_e, queue_s, queue_w;
  logic [3:0]    ovf;

  vehicle_detector #(.DEBOUNCE(4), .DEPART(8), .QW(QW)) dut (
    .clk(clk), .rst(rst),
    .loop_n(loop_n), .loop_e(loop_e), .loop_s(loop_s), .loop_w(loop_w),
    .ns_light(ns_light), .ew_light(ew_light), .sn_light(sn_light), .we_light(we_light),
    .sensor_north(sensor_north), .sensor_east(sensor_east),
    .sensor_south(sensor_south), .sensor_west(sensor_west),
    .queue_n(queue_n), .queue_e(queue_e), .queue_s(queue_s), .queue_w(queue_w),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Signal selectors: 0..3 queue n/e/s/w, 4..7 sensor n/e/s/w, 8 ovf.
  typedef struct {
    string tag;
    int    sel;
    int    exp;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic int sample(int sel);
    case (sel)
      0: return int'(queue_n);
      1: return int'(queue_e);
      2: return int'(queue_s);
      3: return int'(queue_w);
      4: return int'(sensor_north);
      5: return int'(sensor_east);
      6: return int'(sensor_south);
      7: return int'(sensor_west);
      default: return int'(ovf);
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input int exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  // Compare every pending expectation against the DUT now.
  task automatic drain();
    exp_t e;
    int obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = sample(e.sel);
      vectors++;
      assert (obs === e.exp) else begin
        miscompares++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
      end
      $display("check %s: observed %0d expected %0d", e.tag, obs, e.exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  // One full debounced vehicle: 6 edges high (arrival on the 6th), 8 low.
  task automatic vehicle_w();
    loop_w = 1'b1;
    tick(6);
    loop_w = 1'b0;
    tick(8);
  endtask

  initial begin
    // Reset state
    do_reset();
    for (int c = 0; c < 4; c++) begin
      push($sformatf("reset_queue%0d", c), c, 0);
      push($sformatf("reset_sensor%0d", c), c + 4, 0);
    end
    push("reset_ovf", 8, 0);
    drain();

    // Arrival latency on north: loop high at edge 0, arrival at edge 5.
    loop_n = 1'b1;
    tick(5);
    push("north_pre_arrival_q", 0, 0);
    push("north_pre_arrival_sensor", 4, 0);
    drain();
    tick(1);
    push("north_arrival_q", 0, 1);
    push("north_arrival_sensor", 4, 1);
    push("east_untouched", 1, 0);
    push("south_untouched", 2, 0);
    push("west_untouched", 3, 0);
    push("ovf_untouched", 8, 0);
    drain();
    tick(4);
    push("north_held_q", 0, 1);
    drain();
    loop_n = 1'b0;
    tick(8);

    // Glitch on east: 2 cycles high, no arrival.
    loop_e = 1'b1;
    tick(2);
    loop_e = 1'b0;
    tick(10);
    push("east_glitch_q", 1, 0);
    push("east_glitch_sensor", 5, 0);
    drain();

    // South: three arrivals, then green drains one every 8 edges.
    for (int v = 0; v < 3; v++) begin
      loop_s = 1'b1;
      tick(6);
      loop_s = 1'b0;
      tick(8);
    end
    push("south_loaded", 2, 3);
    drain();
    sn_light = GREEN;
    for (int i = 0; i < 24; i++) begin
      tick(1);
      push($sformatf("south_green_e%0d_q", i), 2, 3 - (i + 1) / 8);
      push($sformatf("south_green_e%0d_sensor", i), 6, (i < 23) ? 1 : 0);
      drain();
    end
    sn_light = RED;
    tick(2);

    // West saturation: 33 vehicles, red light.
    for (int v = 0; v < 31; v++) vehicle_w();
    push("west_31_q", 3, 31);
    push("west_31_ovf", 8, 0);
    drain();
    vehicle_w();
    vehicle_w();
    push("west_sat_q", 3, 31);
    push("west_sat_ovf", 8, 8);
    push("north_kept_q", 0, 1);
    drain();
    do_reset();
    push("west_rst_q", 3, 0);
    push("west_rst_ovf", 8, 0);
    push("north_rst_q", 0, 0);
    drain();

    // North: queue 1, then arrival and departure on the same edge.
    loop_n = 1'b1;
    tick(6);
    loop_n = 1'b0;
    tick(8);
    push("north_one", 0, 1);
    drain();
    ns_light = GREEN;          // first green at edge 0, departure at edge 7
    tick(2);
    loop_n = 1'b1;             // first high at edge 2, arrival at edge 7
    tick(5);
    push("coincide_pre_q", 0, 1);
    drain();
    tick(1);
    push("coincide_q", 0, 1);
    push("coincide_ovf", 8, 0);
    drain();
    ns_light = RED;
    tick(3);
    push("coincide_after_q", 0, 1);
    drain();
    loop_n = 1'b0;
    tick(8);

    // Reset while east is in RISE: arrival delayed by the reset.
    loop_e = 1'b1;
    tick(3);                   // edges 0..2, FSM enters RISE at edge 2
    rst = 1'b1;
    tick(1);                   // edge 3 resets
    rst = 1'b0;
    push("rst_mid_north_q", 0, 0);
    drain();
    tick(2);                   // edges 4,5: undisturbed arrival would be at 5
    push("rst_mid_east_e5", 1, 0);
    drain();
    tick(3);                   // edges 6..8
    push("rst_mid_east_e8", 1, 0);
    drain();
    tick(1);                   // edge 9
    push("rst_mid_east_e9", 1, 1);
    push("rst_mid_east_sensor", 5, 1);
    drain();
    loop_e = 1'b0;
    tick(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
